// File: rtl/puf_state_machine.sv
// Sequencer for a ring-oscillator PUF array: sweeps every loop REPETITIONS times,
// issuing reset / enable-for-EVAL_TIME / store pulses per loop, then raises done.
module puf_state_machine #(
    parameter int NUM_LOOPS        = 4,
    parameter int REPETITIONS_BITS = 16,
    parameter int REPETITIONS      = 2,
    parameter int EVAL_TIME_BITS   = 16,
    parameter int EVAL_TIME        = 8,
    parameter int CHALLENGE_BITS   = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic [CHALLENGE_BITS-1:0]          challenge,
    output logic                               done,
    output logic                               reset_puf,
    output logic [$clog2(NUM_LOOPS-1):0]       select_puf,
    output logic                               enable_puf,
    output logic                               store_response_puf
);

    localparam int LOOP_W = (NUM_LOOPS > 2) ? $clog2(NUM_LOOPS) : 1;
    localparam int SEL_W  = $clog2(NUM_LOOPS - 1) + 1;
    localparam int SUM_W  = ((LOOP_W > CHALLENGE_BITS) ? LOOP_W : CHALLENGE_BITS) + 1;

    localparam logic [LOOP_W-1:0]           LOOP_LAST = LOOP_W'(NUM_LOOPS - 1);
    localparam logic [REPETITIONS_BITS-1:0] REP_LAST  = REPETITIONS_BITS'(REPETITIONS - 1);
    localparam logic [EVAL_TIME_BITS-1:0]   EVAL_LAST = EVAL_TIME_BITS'(EVAL_TIME - 1);
    localparam logic [SUM_W-1:0]            LOOPS_MOD = SUM_W'(NUM_LOOPS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RST   = 3'd1,
        S_EVAL  = 3'd2,
        S_STORE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                       state_q, state_d;
    logic [LOOP_W-1:0]            loop_q, loop_d;
    logic [REPETITIONS_BITS-1:0]  rep_q, rep_d;
    logic [EVAL_TIME_BITS-1:0]    eval_q, eval_d;
    logic [CHALLENGE_BITS-1:0]    chal_q, chal_d;

    logic [SUM_W-1:0]             sel_sum;
    logic [SUM_W-1:0]             sel_mod;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            loop_q  <= '0;
            rep_q   <= '0;
            eval_q  <= '0;
            chal_q  <= '0;
        end else begin
            state_q <= state_d;
            loop_q  <= loop_d;
            rep_q   <= rep_d;
            eval_q  <= eval_d;
            chal_q  <= chal_d;
        end
    end

    always_comb begin
        state_d = state_q;
        loop_d  = loop_q;
        rep_d   = rep_q;
        eval_d  = eval_q;
        chal_d  = chal_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                // A sweep may be (re)started from either resting state.
                if (start) begin
                    chal_d  = challenge;
                    loop_d  = '0;
                    rep_d   = '0;
                    eval_d  = '0;
                    state_d = S_RST;
                end
            end
            S_RST: begin
                eval_d  = '0;
                state_d = S_EVAL;
            end
            S_EVAL: begin
                if (eval_q == EVAL_LAST) begin
                    eval_d  = '0;
                    state_d = S_STORE;
                end else begin
                    eval_d = eval_q + 1'b1;
                end
            end
            S_STORE: begin
                if (loop_q < LOOP_LAST) begin
                    loop_d  = loop_q + 1'b1;
                    state_d = S_RST;
                end else if (rep_q < REP_LAST) begin
                    loop_d  = '0;
                    rep_d   = rep_q + 1'b1;
                    state_d = S_RST;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Challenge rotates the loop order; the sum is wide enough to never wrap before the modulo.
    assign sel_sum = SUM_W'(loop_q) + SUM_W'(chal_q);
    assign sel_mod = sel_sum % LOOPS_MOD;

    always_comb begin
        done               = 1'b0;
        reset_puf          = 1'b0;
        enable_puf         = 1'b0;
        store_response_puf = 1'b0;
        select_puf         = '0;

        unique case (state_q)
            S_RST: begin
                reset_puf  = 1'b1;
                select_puf = SEL_W'(sel_mod);
            end
            S_EVAL: begin
                enable_puf = 1'b1;
                select_puf = SEL_W'(sel_mod);
            end
            S_STORE: begin
                store_response_puf = 1'b1;
                select_puf         = SEL_W'(sel_mod);
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_puf_state_machine.sv
// Directed bench for puf_state_machine: stimulus pushes expected loop selections and
// done latencies into queues; a monitor checks each store pulse and done rise against them.
module tb_puf_state_machine;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [3:0] challenge = 4'd0;
    logic       done;
    logic       reset_puf;
    logic [2:0] select_puf;
    logic       enable_puf;
    logic       store_response_puf;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int exp_sel_q[$];
    int acc_q[$];

    puf_state_machine dut (
        .clk                (clk),
        .reset              (reset),
        .start              (start),
        .challenge          (challenge),
        .done               (done),
        .reset_puf          (reset_puf),
        .select_puf         (select_puf),
        .enable_puf         (enable_puf),
        .store_response_puf (store_response_puf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end else begin
            $display("ok   %s: %0d (t=%0t)", name, act, $time);
        end
    endtask

    function automatic int outs();
        return {27'd0, done, reset_puf, enable_puf, store_response_puf, 1'b0} | int'(select_puf) << 8;
    endfunction

    // Monitor: per-slot bookkeeping, checked at each store pulse and each done rise.
    logic prev_done = 1'b0;
    int   en_cnt    = 0;
    int   rst_seen  = 0;
    int   slot_sel  = 0;
    int   excl_err  = 0;
    always @(negedge clk) begin
        if (reset) begin
            en_cnt = 0; rst_seen = 0; excl_err = 0; prev_done = 1'b0;
        end else begin
            if (int'(reset_puf) + int'(enable_puf) + int'(store_response_puf) > 1) excl_err = 1;
            if (reset_puf) begin
                rst_seen = 1; en_cnt = 0; slot_sel = int'(select_puf);
            end
            if (enable_puf) begin
                en_cnt++;
                if (int'(select_puf) != slot_sel) excl_err = 1;
            end
            if (store_response_puf) begin
                if (exp_sel_q.size() == 0) begin
                    chk("unexpected_store", 1, 0);
                end else begin
                    chk("store_select", int'(select_puf), exp_sel_q.pop_front());
                end
                chk("slot_enable_cycles", en_cnt, 8);
                chk("slot_reset_and_excl", rst_seen + 2 * excl_err, 1);
                rst_seen = 0; en_cnt = 0; excl_err = 0;
            end
            if (done && !prev_done) begin
                if (acc_q.size() == 0) chk("unexpected_done", 1, 0);
                else chk("done_latency", cyc - acc_q.pop_front(), 80);
            end
            prev_done = done;
        end
    end

    task automatic push_sweep(input int ch);
        for (int r = 0; r < 2; r++)
            for (int l = 0; l < 4; l++)
                exp_sel_q.push_back((l + ch) % 4);
    endtask

    // Pulse start for one edge; the accept edge number is queued for the latency check.
    task automatic issue_start(input logic [3:0] ch);
        challenge = ch;
        start = 1'b1;
        push_sweep(int'(ch));
        @(negedge clk);
        start = 1'b0;
        acc_q.push_back(cyc);
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (!done && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (!done) chk("done_timeout", 0, 1);
    endtask

    initial begin
        // 1: reset and quiet idle
        repeat (10) @(negedge clk);
        chk("reset_outputs", outs(), 0);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("idle_outputs", outs(), 0);

        // 2: default sweep, then done holds
        @(negedge clk);
        issue_start(4'd0);
        wait_done(200);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("done_hold", outs(), 32'h10);
        end

        // 3: rotated order, challenge changes mid-sweep are ignored
        issue_start(4'd3);
        repeat (15) @(negedge clk);
        challenge = 4'd5;
        repeat (30) @(negedge clk);
        challenge = 4'd1;
        wait_done(200);
        chk("done_after_rotated", int'(done), 1);

        // 4: start during EVAL of loop 1 is ignored
        @(negedge clk);
        issue_start(4'd0);
        repeat (13) @(negedge clk);
        chk("in_eval_loop1", {28'd0, enable_puf, select_puf}, 32'h9);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(200);

        // 5: reset during EVAL of repetition 1 aborts without done
        issue_start(4'd2);
        repeat (44) @(negedge clk);
        chk("rep1_eval_before_abort", int'(enable_puf), 1);
        #2 reset = 1'b1;
        #1 chk("abort_outputs", outs(), 0);
        exp_sel_q.delete();
        acc_q.delete();
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("no_done_after_abort", outs(), 0);
        issue_start(4'd1);
        wait_done(200);

        // 6: restart directly from DONE
        @(negedge clk);
        issue_start(4'd2);
        chk("done_falls_on_restart", int'(done), 0);
        wait_done(200);
        @(negedge clk);

        chk("stores_outstanding", exp_sel_q.size(), 0);
        chk("done_outstanding", acc_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
